// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS-subset control unit.
// A state register plus combinational decoding of state, op, funct,
// zero and mem_ready into datapath controls. The outputs decode the
// current state directly because FETCH and MEMWR react to mem_ready in
// the same cycle.
module mc_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] alu_control,
    output logic [1:0] pc_source,
    output logic       ext_zero,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEX   = 4'd6,  S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,  S_IMMEX  = 4'd9,  S_IMMWB  = 4'd10, S_JUMP   = 4'd11,
        S_ERR    = 4'd12
    } state_t;

    localparam logic [3:0] ALU_AND = 4'd0, ALU_OR  = 4'd1, ALU_ADD = 4'd2, ALU_SLL = 4'd3,
                           ALU_SRL = 4'd4, ALU_LUI = 4'd5, ALU_SUB = 4'd6, ALU_SLT = 4'd7,
                           ALU_NOR = 4'd8, ALU_XOR = 4'd9;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_BEQ  = 6'h04, OP_BNE = 6'h05,
                           OP_ADDI  = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                           OP_LUI   = 6'h0F, OP_LW   = 6'h23, OP_SW   = 6'h2B;

    // ALU code for an R-type funct; unknown functs never reach RTEX.
    function automatic logic [3:0] rt_alu_code(input logic [5:0] f);
        case (f)
            6'h20:   rt_alu_code = ALU_ADD;
            6'h22:   rt_alu_code = ALU_SUB;
            6'h24:   rt_alu_code = ALU_AND;
            6'h25:   rt_alu_code = ALU_OR;
            6'h26:   rt_alu_code = ALU_XOR;
            6'h27:   rt_alu_code = ALU_NOR;
            6'h2A:   rt_alu_code = ALU_SLT;
            6'h00:   rt_alu_code = ALU_SLL;
            6'h02:   rt_alu_code = ALU_SRL;
            default: rt_alu_code = ALU_ADD;
        endcase
    endfunction

    // True for the R-type functs this controller can execute.
    function automatic logic rt_funct_legal(input logic [5:0] f);
        case (f)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h26,
            6'h27, 6'h2A, 6'h00, 6'h02: rt_funct_legal = 1'b1;
            default:                   rt_funct_legal = 1'b0;
        endcase
    endfunction

    // Shifts take the shift amount from the immediate field and the operand from regB.
    function automatic logic rt_is_shift(input logic [5:0] f);
        rt_is_shift = (f == 6'h00) || (f == 6'h02);
    endfunction

    state_t state_r;
    state_t next_state_s;
    state_t dec_state_s;

    // While reset is held the outputs show FETCH decoding.
    assign dec_state_s = reset ? S_FETCH : state_r;
    assign state       = state_r;

    // State register with synchronous reset that overrides any pending transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; encodings outside the enum fall back to FETCH.
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH:  next_state_s = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:                                 next_state_s = rt_funct_legal(funct) ? S_RTEX : S_ERR;
                    OP_LW, OP_SW:                             next_state_s = S_MEMADR;
                    OP_BEQ, OP_BNE:                           next_state_s = S_BRANCH;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: next_state_s = S_IMMEX;
                    OP_J:                                     next_state_s = S_JUMP;
                    default:                                  next_state_s = S_ERR;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW) begin
                    next_state_s = S_MEMRD;
                end else if (op == OP_SW) begin
                    next_state_s = S_MEMWR;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_MEMRD:  next_state_s = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  next_state_s = S_FETCH;
            S_MEMWR:  next_state_s = mem_ready ? S_FETCH : S_MEMWR;
            S_RTEX:   next_state_s = S_RTWB;
            S_RTWB:   next_state_s = S_FETCH;
            S_BRANCH: next_state_s = S_FETCH;
            S_IMMEX:  next_state_s = S_IMMWB;
            S_IMMWB:  next_state_s = S_FETCH;
            S_JUMP:   next_state_s = S_FETCH;
            S_ERR:    next_state_s = S_ERR;
            default:  next_state_s = S_FETCH;
        endcase
    end

    // Datapath control decode from the (reset-adjusted) current state.
    always_comb begin
        pc_write    = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 2'd0;
        alu_src_b   = 2'd0;
        alu_control = ALU_AND;
        pc_source   = 2'd0;
        ext_zero    = 1'b0;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        case (dec_state_s)
            S_FETCH: begin
                mem_read    = 1'b1;
                alu_src_b   = 2'd1;
                alu_control = ALU_ADD;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end else begin
                    ir_write = 1'b0;
                    pc_write = 1'b0;
                end
            end
            S_DECODE: begin
                alu_src_b   = 2'd3;
                alu_control = ALU_ADD;
            end
            S_MEMADR: begin
                alu_src_a   = 2'd1;
                alu_src_b   = 2'd2;
                alu_control = ALU_ADD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                instr_done = mem_ready;
            end
            S_RTEX: begin
                if (rt_is_shift(funct)) begin
                    alu_src_a = 2'd2;
                    alu_src_b = 2'd2;
                end else begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd0;
                end
                alu_control = rt_alu_code(funct);
            end
            S_RTWB: begin
                // ALU code is held through writeback so the result path stays quiet.
                reg_write   = 1'b1;
                reg_dst     = 1'b1;
                instr_done  = 1'b1;
                alu_control = rt_alu_code(funct);
            end
            S_BRANCH: begin
                alu_src_a   = 2'd1;
                alu_control = ALU_SUB;
                pc_source   = 2'd1;
                instr_done  = 1'b1;
                if (op == OP_BEQ) begin
                    pc_write = zero;
                end else if (op == OP_BNE) begin
                    pc_write = ~zero;
                end else begin
                    pc_write = 1'b0;
                end
            end
            S_IMMEX: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                case (op)
                    OP_ADDI: alu_control = ALU_ADD;
                    OP_SLTI: alu_control = ALU_SLT;
                    OP_ANDI: begin
                        alu_control = ALU_AND;
                        ext_zero    = 1'b1;
                    end
                    OP_ORI: begin
                        alu_control = ALU_OR;
                        ext_zero    = 1'b1;
                    end
                    OP_LUI:  alu_control = ALU_LUI;
                    default: alu_control = ALU_ADD;
                endcase
            end
            S_IMMWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'd2;
                instr_done = 1'b1;
            end
            S_ERR: begin
                illegal = 1'b1;
            end
            default: begin
                illegal = 1'b0;
            end
        endcase
        if (reset) begin
            pc_write = 1'b0;
            ir_write = 1'b0;
            mem_read = 1'b0;
        end else begin
            illegal = illegal;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed testbench for mc_ctrl: walks each instruction class through
// its state sequence and compares controls against hand-derived values.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic [1:0] alu_src_a, alu_src_b, pc_source;
    logic [3:0] alu_control, state;
    logic       ext_zero, instr_done, illegal;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .pc_source(pc_source), .ext_zero(ext_zero), .instr_done(instr_done),
        .illegal(illegal), .state(state)
    );

    // Apply inputs just after a falling edge and let the decode settle.
    task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic z, input logic r);
        @(negedge clk);
        op = o; funct = f; zero = z; mem_ready = r;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(6'h00, 6'h00, 1'b0, 1'b1);
        drive(6'h00, 6'h00, 1'b0, 1'b1);
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", state); end
        checks++; if ({illegal, pc_write, ir_write, mem_read} !== 4'b0000) begin errors++; $display("FAIL reset_enables got=%b want=0000", {illegal, pc_write, ir_write, mem_read}); end
        checks++; if ({alu_src_a, alu_src_b, alu_control} !== 8'b00_01_0010) begin errors++; $display("FAIL reset_alu got=%b want=00010010", {alu_src_a, alu_src_b, alu_control}); end
        mem_ready = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_fetch_stall();
        drive(6'h00, 6'h20, 1'b0, 1'b0);
        checks++; if ({state, mem_read, iord, ir_write, pc_write} !== 8'b0000_1000) begin errors++; $display("FAIL fetch_stall got=%b want=00001000", {state, mem_read, iord, ir_write, pc_write}); end
        drive(6'h00, 6'h20, 1'b0, 1'b0);
        checks++; if ({state, mem_read, iord} !== 6'b0000_10) begin errors++; $display("FAIL fetch_stall_hold got=%b want=000010", {state, mem_read, iord}); end
    endtask

    task automatic test_add();
        int done_cnt;
        done_cnt = 0;
        drive(6'h00, 6'h20, 1'b0, 1'b1);
        done_cnt += int'(instr_done);
        checks++; if ({state, ir_write, pc_write, mem_read} !== 7'b0000_111) begin errors++; $display("FAIL add_fetch got=%b want=0000111", {state, ir_write, pc_write, mem_read}); end
        drive(6'h00, 6'h20, 1'b0, 1'b1);
        done_cnt += int'(instr_done);
        checks++; if ({state, alu_src_a, alu_src_b, alu_control} !== 12'b0001_00_11_0010) begin errors++; $display("FAIL add_decode got=%b want=000100110010", {state, alu_src_a, alu_src_b, alu_control}); end
        drive(6'h00, 6'h20, 1'b0, 1'b1);
        done_cnt += int'(instr_done);
        checks++; if ({state, alu_src_a, alu_src_b, alu_control} !== 12'b0110_01_00_0010) begin errors++; $display("FAIL add_rtex got=%b want=011001000010", {state, alu_src_a, alu_src_b, alu_control}); end
        drive(6'h00, 6'h20, 1'b0, 1'b1);
        done_cnt += int'(instr_done);
        checks++; if ({state, reg_write, reg_dst, mem_to_reg, alu_control} !== 11'b0111_110_0010) begin errors++; $display("FAIL add_rtwb got=%b want=01111100010", {state, reg_write, reg_dst, mem_to_reg, alu_control}); end
        drive(6'h00, 6'h20, 1'b0, 1'b0);
        done_cnt += int'(instr_done);
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL add_back_to_fetch got=%0d want=0", state); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL add_done_pulses got=%0d want=1", done_cnt); end
    endtask

    task automatic test_lw_wait();
        drive(6'h23, 6'h00, 1'b0, 1'b1);
        drive(6'h23, 6'h00, 1'b0, 1'b0);
        checks++; if (state !== 4'd1) begin errors++; $display("FAIL lw_decode got=%0d want=1", state); end
        drive(6'h23, 6'h00, 1'b0, 1'b0);
        checks++; if ({state, alu_src_a, alu_src_b, alu_control} !== 12'b0010_01_10_0010) begin errors++; $display("FAIL lw_memadr got=%b want=001001100010", {state, alu_src_a, alu_src_b, alu_control}); end
        for (int i = 0; i < 4; i++) begin
            drive(6'h23, 6'h00, 1'b0, (i == 3));
            checks++; if ({state, mem_read, iord, instr_done} !== 7'b0011_110) begin errors++; $display("FAIL lw_memrd_%0d got=%b want=0011110", i, {state, mem_read, iord, instr_done}); end
        end
        drive(6'h23, 6'h00, 1'b0, 1'b0);
        checks++; if ({state, mem_to_reg, reg_write, reg_dst, instr_done} !== 8'b0100_1101) begin errors++; $display("FAIL lw_memwb got=%b want=01001101", {state, mem_to_reg, reg_write, reg_dst, instr_done}); end
        drive(6'h23, 6'h00, 1'b0, 1'b0);
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL lw_back_to_fetch got=%0d want=0", state); end
    endtask

    task automatic test_branch(input logic [5:0] o, input logic z, input logic exp_pcw);
        drive(o, 6'h00, z, 1'b1);
        drive(o, 6'h00, z, 1'b0);
        drive(o, 6'h00, z, 1'b0);
        checks++; if ({state, pc_write, pc_source, alu_control, instr_done} !== {4'd8, exp_pcw, 2'd1, 4'd6, 1'b1}) begin errors++; $display("FAIL branch_op%0h_z%0d got=%b want=%b", o, z, {state, pc_write, pc_source, alu_control, instr_done}, {4'd8, exp_pcw, 2'd1, 4'd6, 1'b1}); end
        drive(o, 6'h00, z, 1'b0);
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL branch_return got=%0d want=0", state); end
    endtask

    task automatic test_shift_imm();
        drive(6'h00, 6'h00, 1'b0, 1'b1);
        drive(6'h00, 6'h00, 1'b0, 1'b0);
        drive(6'h00, 6'h00, 1'b0, 1'b0);
        checks++; if ({state, alu_src_a, alu_src_b, alu_control} !== 12'b0110_10_10_0011) begin errors++; $display("FAIL sll_rtex got=%b want=011010100011", {state, alu_src_a, alu_src_b, alu_control}); end
        drive(6'h00, 6'h00, 1'b0, 1'b0);
        drive(6'h00, 6'h00, 1'b0, 1'b0);
        drive(6'h0D, 6'h00, 1'b0, 1'b1);
        drive(6'h0D, 6'h00, 1'b0, 1'b0);
        drive(6'h0D, 6'h00, 1'b0, 1'b0);
        checks++; if ({state, ext_zero, alu_control, alu_src_a, alu_src_b} !== 13'b1001_1_0001_01_10) begin errors++; $display("FAIL ori_immex got=%b want=1001100010110", {state, ext_zero, alu_control, alu_src_a, alu_src_b}); end
        drive(6'h0D, 6'h00, 1'b0, 1'b0);
        checks++; if ({state, reg_write, reg_dst, mem_to_reg, instr_done} !== 8'b1010_1001) begin errors++; $display("FAIL ori_immwb got=%b want=10101001", {state, reg_write, reg_dst, mem_to_reg, instr_done}); end
        drive(6'h0D, 6'h00, 1'b0, 1'b0);
    endtask

    task automatic test_jump();
        drive(6'h02, 6'h00, 1'b0, 1'b1);
        drive(6'h02, 6'h00, 1'b0, 1'b0);
        drive(6'h02, 6'h00, 1'b0, 1'b0);
        checks++; if ({state, pc_write, pc_source, instr_done} !== 8'b1011_1_10_1) begin errors++; $display("FAIL jump got=%b want=10111101", {state, pc_write, pc_source, instr_done}); end
        drive(6'h02, 6'h00, 1'b0, 1'b0);
    endtask

    task automatic test_illegal(input logic [5:0] o, input logic [5:0] f, input int hold);
        drive(o, f, 1'b0, 1'b1);
        drive(o, f, 1'b0, 1'b1);
        checks++; if (state !== 4'd1) begin errors++; $display("FAIL ill_decode got=%0d want=1", state); end
        for (int i = 0; i < hold; i++) begin
            drive(o, f, 1'b0, 1'b1);
            checks++; if ({state, illegal, mem_read, pc_write, reg_write} !== 8'b1100_1000) begin errors++; $display("FAIL ill_hold_%0d got=%b want=11001000", i, {state, illegal, mem_read, pc_write, reg_write}); end
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if ({illegal, mem_read} !== 2'b00) begin errors++; $display("FAIL ill_reset_decode got=%b want=00", {illegal, mem_read}); end
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        checks++; if ({state, illegal} !== 5'b0000_0) begin errors++; $display("FAIL ill_after_reset got=%b want=00000", {state, illegal}); end
    endtask

    task automatic test_memwr_reset();
        drive(6'h2B, 6'h00, 1'b0, 1'b1);
        drive(6'h2B, 6'h00, 1'b0, 1'b0);
        drive(6'h2B, 6'h00, 1'b0, 1'b0);
        drive(6'h2B, 6'h00, 1'b0, 1'b0);
        checks++; if ({state, mem_write, iord, instr_done} !== 7'b0101_110) begin errors++; $display("FAIL sw_memwr_wait got=%b want=0101110", {state, mem_write, iord, instr_done}); end
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        checks++; if ({state, mem_write, instr_done} !== 6'b0000_00) begin errors++; $display("FAIL sw_reset got=%b want=000000", {state, mem_write, instr_done}); end
    endtask

    task automatic test_back_to_back();
        drive(6'h2B, 6'h00, 1'b0, 1'b1);
        drive(6'h2B, 6'h00, 1'b0, 1'b0);
        drive(6'h2B, 6'h00, 1'b0, 1'b0);
        drive(6'h2B, 6'h00, 1'b0, 1'b1);
        checks++; if ({state, mem_write, instr_done} !== 6'b0101_11) begin errors++; $display("FAIL b2b_sw_done got=%b want=010111", {state, mem_write, instr_done}); end
        drive(6'h00, 6'h22, 1'b0, 1'b1);
        checks++; if ({state, ir_write, pc_write} !== 6'b0000_11) begin errors++; $display("FAIL b2b_fetch got=%b want=000011", {state, ir_write, pc_write}); end
        drive(6'h00, 6'h22, 1'b0, 1'b0);
        drive(6'h00, 6'h22, 1'b0, 1'b0);
        checks++; if ({state, alu_control} !== 8'b0110_0110) begin errors++; $display("FAIL b2b_sub_rtex got=%b want=01100110", {state, alu_control}); end
        drive(6'h00, 6'h22, 1'b0, 1'b0);
        drive(6'h00, 6'h22, 1'b0, 1'b0);
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL b2b_end got=%0d want=0", state); end
    endtask

    initial begin
        test_reset();
        test_fetch_stall();
        test_add();
        test_lw_wait();
        test_branch(6'h04, 1'b1, 1'b1);
        test_branch(6'h05, 1'b1, 1'b0);
        test_branch(6'h05, 1'b0, 1'b1);
        test_shift_imm();
        test_jump();
        test_illegal(6'h3F, 6'h00, 10);
        test_illegal(6'h00, 6'h3F, 2);
        test_memwr_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
